// File: rtl/rv32_wb_stage.sv
// -----------------------------------------------------------------------------
// rv32_wb_stage
//   Writeback stage of the RV32 pipeline. Accepts one retiring record per
//   handshake from the memory stage. Loads wait for the data-memory response.
//   Load data is aligned and sign/zero-extended here. The stage drives the
//   register file's single write port with a one-cycle write pulse, and it
//   reports retirement and load faults.
//
// Parameters
//   XLEN     datapath width (only 32 is supported)
//   DROP_X0  1: writes to x0 are suppressed (wb_wen stays 0)
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        record handshake from the memory stage
//   in_rd, in_wb_sel           destination index, result source
//                              (00 none, 01 ALU, 10 load, 11 PC+4)
//   in_funct3, in_addr_lo      load type and low load-address bits
//   in_alu_res, in_pc4         non-load result candidates
//   dmem_rvalid/rdata/err      load response (err qualified by rvalid)
//   wb_rd, wb_wen, wb_data     register-file write port (registered)
//   retire, load_fault         one-cycle status pulses (registered)
// -----------------------------------------------------------------------------
module rv32_wb_stage #(
  parameter int XLEN    = 32,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_pc4,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_err,
  output logic [4:0]      wb_rd,
  output logic            wb_wen,
  output logic [XLEN-1:0] wb_data,
  output logic            retire,
  output logic            load_fault
);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  state_t r_state;
  state_t w_state_next;

  // Pending load context, captured at accept time
  logic [4:0] r_ld_rd;
  logic [2:0] r_ld_funct3;
  logic [1:0] r_ld_addr_lo;

  // Registered outputs
  logic [4:0]      r_wb_rd;
  logic            r_wb_wen;
  logic [XLEN-1:0] r_wb_data;
  logic            r_retire;
  logic            r_load_fault;

  // Next-cycle values
  logic            w_ld_capture;
  logic            w_wen_next;
  logic            w_retire_next;
  logic            w_fault_next;
  logic [4:0]      w_rd_next;
  logic [XLEN-1:0] w_data_next;

  // Load lane extraction
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ld_value;
  logic            w_ld_bad;

  always_comb begin
    w_byte = 8'h00;
    case (r_ld_addr_lo)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_ld_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  // Format the response and flag misalignment / illegal funct3
  always_comb begin
    w_ld_value = '0;
    w_ld_bad   = 1'b0;
    case (r_ld_funct3)
      3'b000: w_ld_value = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100: w_ld_value = {{(XLEN-8){1'b0}}, w_byte};
      3'b001: begin
        w_ld_value = {{(XLEN-16){w_half[15]}}, w_half};
        w_ld_bad   = r_ld_addr_lo[0];
      end
      3'b101: begin
        w_ld_value = {{(XLEN-16){1'b0}}, w_half};
        w_ld_bad   = r_ld_addr_lo[0];
      end
      3'b010: begin
        w_ld_value = dmem_rdata;
        w_ld_bad   = (r_ld_addr_lo != 2'b00);
      end
      default: w_ld_bad = 1'b1;
    endcase
  end

  assign in_ready = (r_state == S_IDLE);

  // Next-state and next-output logic
  always_comb begin
    w_state_next  = r_state;
    w_ld_capture  = 1'b0;
    w_wen_next    = 1'b0;
    w_retire_next = 1'b0;
    w_fault_next  = 1'b0;
    w_rd_next     = r_wb_rd;
    w_data_next   = r_wb_data;

    case (r_state)
      S_IDLE: begin
        // dmem_rvalid is deliberately not looked at here: a response that
        // arrives while idle (or during the accept cycle) has no owner.
        if (in_valid) begin
          if (in_wb_sel == SEL_LOAD) begin
            w_ld_capture = 1'b1;
            w_state_next = S_WAIT_LOAD;
          end else begin
            w_retire_next = 1'b1;
            w_rd_next     = in_rd;
            w_data_next   = (in_wb_sel == SEL_ALU) ? in_alu_res : in_pc4;
            w_wen_next    = (in_wb_sel != SEL_NONE) &&
                            !(DROP_X0 && (in_rd == 5'd0));
          end
        end
      end

      S_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          w_state_next  = S_IDLE;
          w_retire_next = 1'b1;
          if (dmem_err || w_ld_bad) begin
            w_fault_next = 1'b1;
          end else begin
            w_rd_next   = r_ld_rd;
            w_data_next = w_ld_value;
            w_wen_next  = !(DROP_X0 && (r_ld_rd == 5'd0));
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ld_rd      <= 5'd0;
      r_ld_funct3  <= 3'd0;
      r_ld_addr_lo <= 2'd0;
      r_wb_rd      <= 5'd0;
      r_wb_wen     <= 1'b0;
      r_wb_data    <= '0;
      r_retire     <= 1'b0;
      r_load_fault <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wb_wen     <= w_wen_next;
      r_retire     <= w_retire_next;
      r_load_fault <= w_fault_next;
      if (w_ld_capture) begin
        r_ld_rd      <= in_rd;
        r_ld_funct3  <= in_funct3;
        r_ld_addr_lo <= in_addr_lo;
      end
      // Index and data only move on a real write, so they hold across
      // suppressed x0 writes, "none" records and faulted loads.
      if (w_wen_next) begin
        r_wb_rd   <= w_rd_next;
        r_wb_data <= w_data_next;
      end
    end
  end

  assign wb_rd      = r_wb_rd;
  assign wb_wen     = r_wb_wen;
  assign wb_data    = r_wb_data;
  assign retire     = r_retire;
  assign load_fault = r_load_fault;

endmodule

// File: tb/tb_rv32_wb_stage.sv
module tb_rv32_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic [31:0] in_pc4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_data;
  logic        retire;
  logic        load_fault;

  int n_checks;
  int n_errors;

  rv32_wb_stage #(.XLEN(32), .DROP_X0(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_wb_sel  (in_wb_sel),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .in_alu_res (in_alu_res),
    .in_pc4     (in_pc4),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .dmem_err   (dmem_err),
    .wb_rd      (wb_rd),
    .wb_wen     (wb_wen),
    .wb_data    (wb_data),
    .retire     (retire),
    .load_fault (load_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  waitc;
    logic        exp_wen;
    logic        exp_fault;
    logic        chk_rd;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [4:0] rd, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [1:0] lo,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] rdata, input logic err,
                              input logic [3:0] waitc, input logic exp_wen,
                              input logic exp_fault, input logic [31:0] exp_data);
    vec_t v;
    v.rd = rd; v.sel = sel; v.f3 = f3; v.lo = lo;
    v.alu = alu; v.pc4 = pc4; v.rdata = rdata; v.err = err;
    v.waitc = waitc; v.exp_wen = exp_wen; v.exp_fault = exp_fault;
    v.chk_rd = exp_wen; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    in_valid    = 1'b0;
    in_rd       = 5'd0;
    in_wb_sel   = 2'b00;
    in_funct3   = 3'd0;
    in_addr_lo  = 2'd0;
    in_alu_res  = 32'h0;
    in_pc4      = 32'h0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    dmem_err    = 1'b0;
  endtask

  // Called at a falling edge; returns at a falling edge with outputs checked.
  // Consecutive calls produce back-to-back accepts.
  task automatic apply(input int idx, input vec_t v);
    in_valid   = 1'b1;
    in_rd      = v.rd;
    in_wb_sel  = v.sel;
    in_funct3  = v.f3;
    in_addr_lo = v.lo;
    in_alu_res = v.alu;
    in_pc4     = v.pc4;
    // A response during the accept (idle) cycle must be ignored
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    dmem_err    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
    if (v.sel == 2'b10) begin
      check($sformatf("v%0d ready_after_accept", idx), {31'b0, in_ready}, 32'd0);
      check($sformatf("v%0d no_early_retire", idx), {31'b0, retire}, 32'd0);
      for (int w = 0; w < int'(v.waitc); w++) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d ready_wait%0d", idx, w), {31'b0, in_ready}, 32'd0);
        check($sformatf("v%0d wen_wait%0d", idx, w), {31'b0, wb_wen}, 32'd0);
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = v.rdata;
      dmem_err    = v.err;
      @(posedge clk);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_err    = 1'b0;
    end
    check($sformatf("v%0d retire", idx), {31'b0, retire}, 32'd1);
    check($sformatf("v%0d wen", idx), {31'b0, wb_wen}, {31'b0, v.exp_wen});
    check($sformatf("v%0d fault", idx), {31'b0, load_fault}, {31'b0, v.exp_fault});
    check($sformatf("v%0d data", idx), wb_data, v.exp_data);
    check($sformatf("v%0d ready", idx), {31'b0, in_ready}, 32'd1);
    if (v.chk_rd)
      check($sformatf("v%0d rd", idx), {27'b0, wb_rd}, {27'b0, v.rd});
    $display("vec %0d: sel=%0b f3=%0b lo=%0d rd=%0d -> wen=%0b fault=%0b rd=%0d data=0x%08h",
             idx, v.sel, v.f3, v.lo, v.rd, wb_wen, load_fault, wb_rd, wb_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Expected values worked out by hand; data holds across non-writes.
    //              rd     sel    f3      lo    alu           pc4           rdata         err w  wen flt data
    vecs[0]  = mk(5'd5,  2'b01, 3'b000, 2'd0, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 1, 0, 32'h1234_5678);
    vecs[1]  = mk(5'd1,  2'b01, 3'b000, 2'd0, 32'hAAAA_5555, 32'h0,        32'h0,        0, 0, 1, 0, 32'hAAAA_5555);
    vecs[2]  = mk(5'd2,  2'b11, 3'b000, 2'd0, 32'h5555_0000, 32'h0000_0104, 32'h0,       0, 0, 1, 0, 32'h0000_0104);
    vecs[3]  = mk(5'd3,  2'b00, 3'b000, 2'd0, 32'h7777_7777, 32'h8888_8888, 32'h0,       0, 0, 0, 0, 32'h0000_0104);
    vecs[4]  = mk(5'd0,  2'b01, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0000_0104);
    vecs[5]  = mk(5'd7,  2'b10, 3'b000, 2'd3, 32'h0,        32'h0,        32'h80FF_0011, 0, 3, 1, 0, 32'hFFFF_FF80);
    vecs[6]  = mk(5'd8,  2'b10, 3'b101, 2'd2, 32'h0,        32'h0,        32'h80FF_0011, 0, 1, 1, 0, 32'h0000_80FF);
    vecs[7]  = mk(5'd9,  2'b10, 3'b010, 2'd1, 32'h0,        32'h0,        32'h80FF_0011, 0, 0, 0, 1, 32'h0000_80FF);
    vecs[8]  = mk(5'd10, 2'b10, 3'b010, 2'd0, 32'h0,        32'h0,        32'h80FF_0011, 1, 2, 0, 1, 32'h0000_80FF);
    vecs[9]  = mk(5'd11, 2'b10, 3'b001, 2'd0, 32'h0,        32'h0,        32'h7FFF_8001, 0, 0, 1, 0, 32'hFFFF_8001);
    vecs[10] = mk(5'd12, 2'b10, 3'b100, 2'd1, 32'h0,        32'h0,        32'h7FFF_8001, 0, 0, 1, 0, 32'h0000_0080);
    vecs[11] = mk(5'd13, 2'b10, 3'b001, 2'd1, 32'h0,        32'h0,        32'h7FFF_8001, 0, 0, 0, 1, 32'h0000_0080);
    vecs[12] = mk(5'd14, 2'b10, 3'b011, 2'd0, 32'h0,        32'h0,        32'h1234_5678, 0, 0, 0, 1, 32'h0000_0080);
    vecs[13] = mk(5'd15, 2'b10, 3'b010, 2'd0, 32'h0,        32'h0,        32'hCAFE_BABE, 0, 1, 1, 0, 32'hCAFE_BABE);
    vecs[14] = mk(5'd0,  2'b10, 3'b000, 2'd0, 32'h0,        32'h0,        32'h0000_007F, 0, 0, 0, 0, 32'hCAFE_BABE);
    vecs[15] = mk(5'd16, 2'b10, 3'b000, 2'd1, 32'h0,        32'h0,        32'h0000_7F00, 0, 0, 1, 0, 32'h0000_007F);

    drive_idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset ready", {31'b0, in_ready}, 32'd1);
    check("reset wen", {31'b0, wb_wen}, 32'd0);
    check("reset rd", {27'b0, wb_rd}, 32'd0);
    check("reset data", wb_data, 32'd0);
    check("reset retire", {31'b0, retire}, 32'd0);
    check("reset fault", {31'b0, load_fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset ready", {31'b0, in_ready}, 32'd1);
    check("post-reset retire", {31'b0, retire}, 32'd0);

    for (int i = 0; i < NVEC; i++) apply(i, vecs[i]);

    // Idle cycle afterwards: pulses must have dropped, data held
    @(posedge clk);
    @(negedge clk);
    check("idle retire", {31'b0, retire}, 32'd0);
    check("idle wen", {31'b0, wb_wen}, 32'd0);
    check("idle data hold", wb_data, 32'h0000_007F);

    // Reset while a load is pending, then a stray response
    in_valid   = 1'b1;
    in_rd      = 5'd20;
    in_wb_sel  = 2'b10;
    in_funct3  = 3'b010;
    in_addr_lo = 2'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst-seq pending ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst-seq async ready", {31'b0, in_ready}, 32'd1);
    check("rst-seq async data", wb_data, 32'd0);
    check("rst-seq async rd", {27'b0, wb_rd}, 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("rst-seq wen", {31'b0, wb_wen}, 32'd0);
    check("rst-seq retire", {31'b0, retire}, 32'd0);
    check("rst-seq fault", {31'b0, load_fault}, 32'd0);
    check("rst-seq ready", {31'b0, in_ready}, 32'd1);
    check("rst-seq data", wb_data, 32'd0);
    check("rst-seq rd", {27'b0, wb_rd}, 32'd0);
    $display("reset-during-load: wen=%0b retire=%0b fault=%0b ready=%0b data=0x%08h",
             wb_wen, retire, load_fault, in_ready, wb_data);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
